// File: rtl/pll_dphase_ctrl.sv
// pll_dphase_ctrl
//   Run-time controller for the ECP5 EHXPLLL dynamic-phase port. It accepts
//   per-channel absolute phase targets and picks the shortest rotation
//   direction. It then emits timed PHASESTEP pulses and one PHASELOADREG pulse,
//   and it tracks the resulting phase of every controlled output.
//
//   Optional feature macro: PLL_DPHASE_LOCK_WAIT_EN
//     When defined, the controller waits for PLL re-lock after the load pulse
//     and times out after LOCK_TMO cycles. It also refuses requests while the
//     PLL is unlocked.
//
// Ports
//   clkin        : single clock (PLL reference domain)
//   rstn         : asynchronous active-low reset
//   req_valid    : phase request valid
//   req_ready    : controller idle and able to accept a request
//   req_ch       : target channel (0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3)
//   req_phase    : absolute target phase, 0..MOD-1
//   pll_locked   : PLL LOCK output (used only with the optional feature)
//   phasesel     : PHASESEL1:0
//   phasedir     : PHASEDIR, 0 = advance, 1 = delay
//   phasestep    : PHASESTEP, idles high
//   phaseloadreg : PHASELOADREG, idles high
//   cur_phase    : tracked phase, channel n at [n*PHASE_W +: PHASE_W]
//   done         : one-cycle pulse when a request completes
//   err          : one-cycle pulse on a rejected or timed-out request
module pll_dphase_ctrl #(
  parameter int CHANNELS  = 4,
  parameter int PHASE_W   = 4,
  parameter int MOD       = 16,
  parameter int PULSE_CYC = 4,
  parameter int SETUP_CYC = 2,
  parameter int LOCK_TMO  = 1024
) (
  input  logic                          clkin,
  input  logic                          rstn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_ch,
  input  logic [PHASE_W-1:0]            req_phase,
  input  logic                          pll_locked,
  output logic [1:0]                    phasesel,
  output logic                          phasedir,
  output logic                          phasestep,
  output logic                          phaseloadreg,
  output logic [CHANNELS*PHASE_W-1:0]   cur_phase,
  output logic                          done,
  output logic                          err
);

  localparam int PW1 = PHASE_W + 1;

`ifdef PLL_DPHASE_LOCK_WAIT_EN
  localparam int CNT_MAX0 = (PULSE_CYC > SETUP_CYC) ? PULSE_CYC : SETUP_CYC;
  localparam int CNT_MAX  = (LOCK_TMO > CNT_MAX0) ? LOCK_TMO : CNT_MAX0;
`else
  localparam int CNT_MAX  = (PULSE_CYC > SETUP_CYC) ? PULSE_CYC : SETUP_CYC;
  localparam int unused_lock_tmo = LOCK_TMO;
`endif
  // The counter is loaded with (duration - 1) and counts down to zero.
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STEP_LO,
    S_STEP_HI,
    S_LOAD,
    S_LOAD_HI,
    S_FIN,
    S_WAIT_LOCK
  } state_t;

  state_t               state_q, state_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [PHASE_W-1:0]   steps_q, steps_n;
  logic [PHASE_W-1:0]   cur_q [CHANNELS];
  logic [1:0]           sel_n;
  logic                 dir_n;
  logic                 err_n;
  logic                 ready_n;
  logic                 step_upd;
  logic                 accept;
  logic                 req_bad;
  logic                 cnt_zero;

  // Shortest-rotation arithmetic for the requested channel.
  logic [PHASE_W-1:0]   cur_req;
  logic [PW1-1:0]       delta;
  logic [PW1-1:0]       steps_w;
  logic [PHASE_W-1:0]   calc_steps;
  logic                 calc_dir;

  // Phase of the channel being stepped, and its value after one step.
  logic [PHASE_W-1:0]   cur_act;
  logic [PHASE_W-1:0]   cur_stepped;

`ifdef PLL_DPHASE_LOCK_WAIT_EN
  assign accept = req_valid && req_ready && pll_locked;
`else
  assign accept = req_valid && req_ready;
  logic unused_lock;
  assign unused_lock = pll_locked;
`endif

  assign req_bad  = (int'(req_ch) >= CHANNELS) || (int'(req_phase) >= MOD);
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    cur_req = '0;
    cur_act = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (req_ch == 2'(i))   cur_req = cur_q[i];
      if (phasesel == 2'(i)) cur_act = cur_q[i];
    end
  end

  always_comb begin
    if (req_phase >= cur_req) delta = {1'b0, req_phase} - {1'b0, cur_req};
    else                      delta = {1'b0, req_phase} + PW1'(MOD) - {1'b0, cur_req};
    // A tie at exactly MOD/2 advances.
    if (delta <= PW1'(MOD / 2)) begin
      calc_dir = 1'b0;
      steps_w  = delta;
    end else begin
      calc_dir = 1'b1;
      steps_w  = PW1'(MOD) - delta;
    end
    calc_steps = PHASE_W'(steps_w);
  end

  always_comb begin
    if (phasedir) cur_stepped = (cur_act == '0) ? PHASE_W'(MOD - 1) : cur_act - 1'b1;
    else          cur_stepped = (cur_act == PHASE_W'(MOD - 1)) ? '0 : cur_act + 1'b1;
  end

  // NOTE: every signal driven here gets a default first so that no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    steps_n  = steps_q;
    sel_n    = phasesel;
    dir_n    = phasedir;
    err_n    = 1'b0;
    step_upd = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_bad) begin
            err_n = 1'b1;
          end else if (calc_steps == '0) begin
            state_n = S_FIN;
          end else begin
            state_n = S_SETUP;
            cnt_n   = CNT_W'(SETUP_CYC - 1);
            steps_n = calc_steps;
            sel_n   = req_ch;
            dir_n   = calc_dir;
          end
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_n = S_STEP_LO;
          cnt_n   = CNT_W'(PULSE_CYC - 1);
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_STEP_LO: begin
        if (cnt_zero) begin
          state_n = S_STEP_HI;
          cnt_n   = CNT_W'(PULSE_CYC - 1);
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_STEP_HI: begin
        if (cnt_zero) begin
          step_upd = 1'b1;
          steps_n  = steps_q - 1'b1;
          state_n  = (steps_q == PHASE_W'(1)) ? S_LOAD : S_STEP_LO;
          cnt_n    = CNT_W'(PULSE_CYC - 1);
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_LOAD: begin
        if (cnt_zero) begin
          state_n = S_LOAD_HI;
          cnt_n   = CNT_W'(PULSE_CYC - 1);
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_LOAD_HI: begin
        if (cnt_zero) begin
`ifdef PLL_DPHASE_LOCK_WAIT_EN
          state_n = S_WAIT_LOCK;
          cnt_n   = CNT_W'(LOCK_TMO - 1);
`else
          state_n = S_FIN;
`endif
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
`ifdef PLL_DPHASE_LOCK_WAIT_EN
      S_WAIT_LOCK: begin
        if (pll_locked) begin
          state_n = S_FIN;
        end else if (cnt_zero) begin
          // Timed out: the steps were applied, so the tracked phase stays.
          state_n = S_IDLE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

`ifdef PLL_DPHASE_LOCK_WAIT_EN
  assign ready_n = (state_n == S_IDLE) && pll_locked;
`else
  assign ready_n = (state_n == S_IDLE);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      steps_q      <= '0;
      req_ready    <= 1'b1;
      phasesel     <= 2'd0;
      phasedir     <= 1'b0;
      phasestep    <= 1'b1;
      phaseloadreg <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      steps_q      <= steps_n;
      req_ready    <= ready_n;
      phasesel     <= sel_n;
      phasedir     <= dir_n;
      // Pins are decoded from the next state so that they are registered
      // and change on the same edge as the state they belong to.
      phasestep    <= (state_n != S_STEP_LO);
      phaseloadreg <= (state_n != S_LOAD);
      done         <= (state_q == S_FIN);
      err          <= err_n;
    end
  end

  // NOTE: the phase table is a small register array that must read back as
  // zero after reset, so it is reset like any other state register.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CHANNELS; i++) cur_q[i] <= '0;
    end else if (step_upd) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (phasesel == 2'(i)) cur_q[i] <= cur_stepped;
      end
    end
  end

  always_comb begin
    cur_phase = '0;
    for (int i = 0; i < CHANNELS; i++) cur_phase[i*PHASE_W +: PHASE_W] = cur_q[i];
  end

endmodule
